// File: rtl/i2c_pkg.sv
// Shared types and constants for the write-only I2C master sequencer.
package i2c_pkg;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_ADDR      = 3'd2,
        ST_ADDR_ACK  = 3'd3,
        ST_WAIT_DATA = 3'd4,
        ST_DATA      = 3'd5,
        ST_DATA_ACK  = 3'd6,
        ST_STOP      = 3'd7
    } state_e;

    // Quarter phases inside one SCL bit cell
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // R/W bit appended to the address byte (this master only writes)
    localparam logic RW_WRITE = 1'b0;

    // Number of repeated-START retries allowed after an address NACK
    localparam logic [1:0] RETRY_LIMIT = 2'd3;

endpackage

// File: rtl/i2c_bit_counter.sv
// Bit counter for one byte: loads 7, counts down to 0 and holds there.
module i2c_bit_counter (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);
    logic [2:0] cnt_q;

    // Load has priority; decrement saturates at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 3'd0;
        end else if (load_i) begin
            cnt_q <= 3'd7;
        end else if (dec_i && (cnt_q != 3'd0)) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/i2c_master_tx_ctrl.sv
// Write-only I2C master: START, address byte, data bytes with ACK checks, STOP.
// Optional feature macro: I2C_TX_NACK_RETRY_EN (address NACK -> repeated START,
// up to RETRY_LIMIT retries before reporting nack_err).
module i2c_master_tx_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [6:0] addr_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic       sda_in_i,
    output logic       scl_oe_o,
    output logic       sda_oe_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       nack_err_o
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [1:0]       qtr_q, qtr_d;
    logic [7:0]       shift_q, shift_d;
    logic [6:0]       addr_q, addr_d;
    logic             last_q, last_d;
    logic             nack_q, nack_d;
    logic             scl_oe_q, scl_oe_d;
    logic             sda_oe_q, sda_oe_d;
    logic             tx_ready_q, tx_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             nack_err_q, nack_err_d;
    logic             bc_load, bc_dec, bc_zero;
`ifdef I2C_TX_NACK_RETRY_EN
    logic [1:0]       retry_q, retry_d;
`endif

    i2c_bit_counter u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .load_i (bc_load),
        .dec_i  (bc_dec),
        .zero_o (bc_zero)
    );

    // Quarter-period divider, parked at zero while idle
    always_ff @(posedge clk) begin
        if (rst || (state_q == ST_IDLE) || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign tick = (state_q != ST_IDLE) && (div_q == DIV_MAX);

    // Next-state and line control; lines only move on quarter ticks
    always_comb begin
        state_d    = state_q;
        qtr_d      = qtr_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        last_d     = last_q;
        nack_d     = nack_q;
        scl_oe_d   = scl_oe_q;
        sda_oe_d   = sda_oe_q;
        tx_ready_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        nack_err_d = nack_err_q;
        bc_load    = 1'b0;
        bc_dec     = 1'b0;
`ifdef I2C_TX_NACK_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
                // The cycle carrying done is still IDLE but must not accept
                if (start_i && !done_q) begin
                    addr_d     = addr_i;
                    nack_err_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_START;
                    // Fresh START skips Q0: lines are already released
                    qtr_d      = Q1;
`ifdef I2C_TX_NACK_RETRY_EN
                    retry_d    = 2'd0;
`endif
                end
            end
            ST_START: begin
                // Q0 releases both lines (needed for a repeated START from SCL low)
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        Q0: begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; end
                        Q1: sda_oe_d = 1'b1;
                        Q3: begin
                            scl_oe_d = 1'b1;
                            state_d  = ST_ADDR;
                            shift_d  = {addr_q, RW_WRITE};
                            bc_load  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ADDR, ST_DATA: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        Q0: begin scl_oe_d = 1'b1; sda_oe_d = ~shift_q[7]; end
                        Q1: scl_oe_d = 1'b0;
                        Q3: begin
                            scl_oe_d = 1'b1;
                            shift_d  = {shift_q[6:0], 1'b0};
                            if (bc_zero) begin
                                state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
                            end else begin
                                bc_dec = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        Q0: begin scl_oe_d = 1'b1; sda_oe_d = 1'b0; end
                        Q1: scl_oe_d = 1'b0;
                        Q2: nack_d = sda_in_i;
                        default: begin
                            scl_oe_d = 1'b1;
                            if (!nack_q) begin
                                state_d = ((state_q == ST_DATA_ACK) && last_q) ? ST_STOP : ST_WAIT_DATA;
                            end else begin
`ifdef I2C_TX_NACK_RETRY_EN
                                if ((state_q == ST_ADDR_ACK) && (retry_q < RETRY_LIMIT)) begin
                                    retry_d = retry_q + 2'd1;
                                    state_d = ST_START;
                                end else begin
                                    nack_err_d = 1'b1;
                                    state_d    = ST_STOP;
                                end
`else
                                nack_err_d = 1'b1;
                                state_d    = ST_STOP;
`endif
                            end
                        end
                    endcase
                end
            end
            ST_WAIT_DATA: begin
                // SCL stays low; ready is raised one cycle after valid is seen
                if (tx_ready_q) begin
                    if (tx_valid_i) begin
                        shift_d = tx_data_i;
                        last_d  = tx_last_i;
                        bc_load = 1'b1;
                        state_d = ST_DATA;
                        qtr_d   = Q0;
                    end
                end else if (tx_valid_i) begin
                    tx_ready_d = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        Q0: sda_oe_d = 1'b1;
                        Q1: scl_oe_d = 1'b0;
                        default: begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_IDLE;
                            qtr_d    = Q0;
                            done_d   = 1'b1;
                            busy_d   = 1'b0;
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            qtr_q      <= Q0;
            shift_q    <= 8'd0;
            addr_q     <= 7'd0;
            last_q     <= 1'b0;
            nack_q     <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_err_q <= 1'b0;
`ifdef I2C_TX_NACK_RETRY_EN
            retry_q    <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            qtr_q      <= qtr_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            nack_q     <= nack_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_err_q <= nack_err_d;
`ifdef I2C_TX_NACK_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign scl_oe_o   = scl_oe_q;
    assign sda_oe_o   = sda_oe_q;
    assign tx_ready_o = tx_ready_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign nack_err_o = nack_err_q;

endmodule

// File: tb/tb_i2c_master_tx_ctrl.sv
// Directed bench for i2c_master_tx_ctrl with a bus monitor and ACK/NACK slave.
`timescale 1ns/1ps
module tb_i2c_master_tx_ctrl;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic [6:0] addr_i = 7'd0;
    logic [7:0] tx_data_i = 8'd0;
    logic       tx_last_i = 1'b0;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o, sda_in_i, scl_oe_o, sda_oe_o, busy_o, done_o, nack_err_o;
    logic       slave_low = 1'b0;

    assign sda_in_i = !(sda_oe_o || slave_low);

    always #5 clk = ~clk;

    i2c_master_tx_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .addr_i     (addr_i),
        .tx_data_i  (tx_data_i),
        .tx_last_i  (tx_last_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .sda_in_i   (sda_in_i),
        .scl_oe_o   (scl_oe_o),
        .sda_oe_o   (sda_oe_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .nack_err_o (nack_err_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor state
    int         bitn, byte_cnt, n_rise, n_start, n_stop, n_ackcell, n_done, n_hs;
    logic [7:0] cap [0:7];
    logic [7:0] sh;
    logic       nack_plan [0:7];
    logic       prev_scl, prev_sda, mon_scl, mon_sda, ready_seen;

    // Data source state
    logic [7:0] src_d [0:3];
    logic       src_l [0:3];
    int         src_n, src_i;
    logic       adv;

    task automatic load_src();
        if (src_i < src_n) begin
            tx_valid_i = 1'b1;
            tx_data_i  = src_d[src_i];
            tx_last_i  = src_l[src_i];
        end else begin
            tx_valid_i = 1'b0;
        end
    endtask

    task automatic clear_mon();
        bitn = 0; byte_cnt = 0; n_rise = 0; n_start = 0; n_stop = 0;
        n_ackcell = 0; n_done = 0; n_hs = 0; sh = 8'd0;
        slave_low = 1'b0; ready_seen = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
        for (int i = 0; i < 8; i++) begin cap[i] = 8'd0; nack_plan[i] = 1'b0; end
        src_n = 0; src_i = 0; adv = 1'b0; tx_valid_i = 1'b0;
    endtask

    // Monitor: decode START/STOP, capture bytes, drive ACK per nack_plan
    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            mon_scl = !scl_oe_o;
            mon_sda = sda_in_i;
            if (done_o) n_done++;
            if (tx_ready_o) ready_seen = 1'b1;
            if (mon_scl && prev_scl && prev_sda && !mon_sda) begin
                n_start++; bitn = 0;
            end else if (mon_scl && prev_scl && !prev_sda && mon_sda) begin
                n_stop++; bitn = 0;
            end else if (mon_scl && !prev_scl) begin
                n_rise++;
                if (bitn < 8) sh = {sh[6:0], mon_sda};
                bitn++;
                if (bitn == 8) begin
                    if (byte_cnt < 8) cap[byte_cnt] = sh;
                    byte_cnt++;
                end
            end else if (!mon_scl && prev_scl) begin
                if (bitn == 8) begin
                    slave_low = (byte_cnt >= 1 && byte_cnt <= 8) ? !nack_plan[byte_cnt-1] : 1'b0;
                end else if (bitn == 9) begin
                    slave_low = 1'b0; bitn = 0; n_ackcell++;
                end
            end
            prev_scl = mon_scl;
            prev_sda = mon_sda;
        end
    end

    // Source: advance to the next byte one cycle after a handshake
    initial begin
        forever begin
            @(negedge clk);
            if (adv) begin adv = 1'b0; src_i++; load_src(); end
            if (tx_valid_i && tx_ready_o) begin adv = 1'b1; n_hs++; end
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        clear_mon();
        @(negedge clk);
    endtask

    task automatic send_start(input logic [6:0] a);
        @(negedge clk); addr_i = a; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done_o && k < 4000) begin @(negedge clk); k++; end
        check_eq({tag, "_done"}, done_o, 1);
        check_eq({tag, "_busy_at_done"}, busy_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic ok;
        repeat (4) @(negedge clk);
        do_reset();
        check_eq("rst_scl_oe", scl_oe_o, 0);
        check_eq("rst_sda_oe", sda_oe_o, 0);
        check_eq("rst_tx_ready", tx_ready_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_nack_err", nack_err_o, 0);

        // T1: addr 0x50, one byte A5 last, all ACK
        src_d[0] = 8'hA5; src_l[0] = 1'b1; src_n = 1; src_i = 0; load_src();
        send_start(7'h50);
        check_eq("t1_busy_after_start", busy_o, 1);
        wait_done("t1");
        start_i = 1'b1; addr_i = 7'h50;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk);
        check_eq("t1_start_in_done_ignored", busy_o, 0);
        repeat (4) @(negedge clk);
        check_eq("t1_addr_byte", cap[0], 8'hA0);
        check_eq("t1_data_byte", cap[1], 8'hA5);
        check_eq("t1_byte_cnt", byte_cnt, 2);
        check_eq("t1_scl_rises", n_rise, 19);
        check_eq("t1_starts", n_start, 1);
        check_eq("t1_stops", n_stop, 1);
        check_eq("t1_done_cnt", n_done, 1);
        check_eq("t1_handshakes", n_hs, 1);
        check_eq("t1_nack_err", nack_err_o, 0);

`ifdef I2C_TX_NACK_RETRY_EN
        // T3: two address NACKs then ACK
        do_reset();
        nack_plan[0] = 1'b1; nack_plan[1] = 1'b1;
        src_d[0] = 8'h5A; src_l[0] = 1'b1; src_n = 1; src_i = 0; load_src();
        send_start(7'h50);
        wait_done("t3");
        repeat (3) @(negedge clk);
        check_eq("t3_byte_cnt", byte_cnt, 4);
        check_eq("t3_addr0", cap[0], 8'hA0);
        check_eq("t3_addr2", cap[2], 8'hA0);
        check_eq("t3_data", cap[3], 8'h5A);
        check_eq("t3_starts", n_start, 3);
        check_eq("t3_handshakes", n_hs, 1);
        check_eq("t3_nack_err", nack_err_o, 0);
        // T2r: four address NACKs exhaust the retries
        do_reset();
        for (int i = 0; i < 4; i++) nack_plan[i] = 1'b1;
        src_d[0] = 8'h33; src_l[0] = 1'b1; src_n = 1; src_i = 0; load_src();
        send_start(7'h50);
        wait_done("t2r");
        repeat (3) @(negedge clk);
        check_eq("t2r_byte_cnt", byte_cnt, 4);
        check_eq("t2r_starts", n_start, 4);
        check_eq("t2r_handshakes", n_hs, 0);
        check_eq("t2r_nack_err", nack_err_o, 1);
`else
        // T2: address NACK goes straight to STOP
        do_reset();
        nack_plan[0] = 1'b1;
        src_d[0] = 8'h33; src_l[0] = 1'b1; src_n = 1; src_i = 0; load_src();
        send_start(7'h50);
        wait_done("t2");
        repeat (3) @(negedge clk);
        check_eq("t2_byte_cnt", byte_cnt, 1);
        check_eq("t2_addr_byte", cap[0], 8'hA0);
        check_eq("t2_no_ready", ready_seen, 0);
        check_eq("t2_nack_err_held", nack_err_o, 1);
        check_eq("t2_stops", n_stop, 1);
        check_eq("t2_done_cnt", n_done, 1);
        send_start(7'h50);
        check_eq("t2_nack_err_cleared", nack_err_o, 0);
        wait_done("t2b");
        check_eq("t2b_data_byte", cap[2], 8'h33);
        check_eq("t2b_nack_err", nack_err_o, 0);
`endif

        // T4: source stalls 20 cycles after the address ACK
        do_reset();
        send_start(7'h2A);
        k = 0;
        while (n_ackcell < 1 && k < 4000) begin @(negedge clk); k++; end
        check_eq("t4_addr_ack_seen", n_ackcell, 1);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!scl_oe_o) ok = 1'b0;
        end
        check_eq("t4_scl_held_low", ok, 1);
        check_eq("t4_no_early_ready", ready_seen, 0);
        src_d[0] = 8'h3C; src_l[0] = 1'b1; src_n = 1; src_i = 0; load_src();
        @(negedge clk);
        check_eq("t4_ready_pulse", tx_ready_o, 1);
        @(negedge clk);
        check_eq("t4_ready_one_cycle", tx_ready_o, 0);
        wait_done("t4");
        repeat (3) @(negedge clk);
        check_eq("t4_addr_byte", cap[0], 8'h54);
        check_eq("t4_data_byte", cap[1], 8'h3C);
        check_eq("t4_handshakes", n_hs, 1);

        // T5: two bytes, second NACKed
        do_reset();
        nack_plan[2] = 1'b1;
        src_d[0] = 8'h01; src_l[0] = 1'b0;
        src_d[1] = 8'hFF; src_l[1] = 1'b1;
        src_n = 2; src_i = 0; load_src();
        send_start(7'h11);
        wait_done("t5");
        repeat (3) @(negedge clk);
        check_eq("t5_byte_cnt", byte_cnt, 3);
        check_eq("t5_addr_byte", cap[0], 8'h22);
        check_eq("t5_data0", cap[1], 8'h01);
        check_eq("t5_data1", cap[2], 8'hFF);
        check_eq("t5_nack_err", nack_err_o, 1);
        check_eq("t5_done_cnt", n_done, 1);
        check_eq("t5_handshakes", n_hs, 2);

        // T6: reset during data bit 3, then a clean transaction
        do_reset();
        src_d[0] = 8'hC3; src_l[0] = 1'b1; src_n = 1; src_i = 0; load_src();
        send_start(7'h50);
        k = 0;
        while (!(n_ackcell == 1 && byte_cnt == 1 && bitn == 4) && k < 4000) begin @(negedge clk); k++; end
        check_eq("t6_reached_bit3", bitn, 4);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_scl_oe", scl_oe_o, 0);
        check_eq("t6_rst_sda_oe", sda_oe_o, 0);
        check_eq("t6_rst_busy", busy_o, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("t6_no_done", n_done, 0);
        @(posedge clk);
        clear_mon();
        src_d[0] = 8'hA5; src_l[0] = 1'b1; src_n = 1; src_i = 0; load_src();
        send_start(7'h50);
        wait_done("t6b");
        repeat (3) @(negedge clk);
        check_eq("t6b_addr_byte", cap[0], 8'hA0);
        check_eq("t6b_data_byte", cap[1], 8'hA5);
        check_eq("t6b_nack_err", nack_err_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
